full_adder: RTL and testbench
=============================

# full_adder

Registered ripple-carry full adder: adds two WIDTH-bit operands plus a carry-in and presents sum and carry-out from output registers one clock after a valid input. WIDTH defaults to 1, giving the classic single-bit full adder used as the arithmetic leaf cell in datapath blocks and in the basic-cell regression suite. A valid strobe travels with the data so downstream logic knows when the outputs are fresh.

## Interface
- WIDTH, 1, operand/sum width in bits; legal range 1–64.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a, b, cin this cycle.
- a  input  WIDTH  operand A, unsigned (two's complement when `ovf` is used).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered sum, a+b+cin modulo 2^WIDTH.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
- out_valid  output  1  high for one cycle per accepted input, aligned with sum/cout.
- ovf  output  1  registered signed overflow; present only with FULL_ADDER_OVF_EN.

## Operation
- Combinational core: WIDTH instances of a 1-bit cell chained LSB→MSB. Cell i computes s_i = a_i^b_i^c_i and c_{i+1} = a_i&b_i | c_i&(a_i^b_i). c_0 = cin. cout = c_WIDTH.
- Arithmetic is exact: {cout,sum} == a + b + cin for every input, computed at WIDTH+1 bits. No saturation.
- When in_valid=1 at a rising edge: sum, cout (and ovf) load the core result. out_valid loads 1.
- When in_valid=0: sum/cout/ovf hold their previous values. out_valid loads 0.
- ovf = c_WIDTH ^ c_{WIDTH-1}, i.e. the sign of a and b agree and differ from sign of sum. For WIDTH=1, ovf = cout ^ cin.
- X/Z on inputs while in_valid=0 must not affect outputs.

## Timing
- Latency: exactly 1 cycle from the in_valid edge to sum/cout/out_valid.
- Throughput: one operation per cycle. Back-to-back valids produce back-to-back out_valid.
- Reset, if rst=1 at an edge: sum=0, cout=0, ovf=0, out_valid=0. rst overrides a simultaneous in_valid, and that input is dropped.
- Reset mid-stream: an operation accepted the cycle before rst asserts still appears for one cycle. The next edge with rst=1 clears it.
- No combinational path from any input to any output.
- Critical path: the WIDTH-deep carry chain. WIDTH≤64 must close at the project's standard clock target.

## Configuration
- FULL_ADDER_OVF_EN defined: the `ovf` port and its register exist, with behaviour as above.
- FULL_ADDER_OVF_EN undefined: no `ovf` port and no overflow logic. All other behaviour is identical.

## Structure
- Package full_adder_pkg: FA_DEFAULT_WIDTH = 1 and FA_MAX_WIDTH = 64 constants, plus a function reference model fa_add(a,b,cin) returning the WIDTH+1-bit result for benches.
- Sub-module fa_bit: purely combinational 1-bit cell (a, b, ci → s, co), instantiated WIDTH times via generate. full_adder holds the chain wiring, output registers, valid pipeline and optional overflow logic.
- Elaboration-time check fails if WIDTH<1 or WIDTH>FA_MAX_WIDTH.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=1,b=1,cin=1 -> sum=0, cout=0, out_valid=0 throughout.
- WIDTH=1 truth table: apply the 8 combinations (a,b,cin) = 000…111 in order, one per cycle with in_valid=1. The {cout,sum} results one cycle later must be 00,01,01,10,01,10,10,11, with out_valid=1 each cycle.
- Hold: after a=1,b=1,cin=0 is accepted (cout=1, sum=0), drive in_valid=0 with a=0,b=0,cin=1 for 3 cycles -> outputs stay cout=1, sum=0, and out_valid=0.
- WIDTH=8 wrap: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1 (with FULL_ADDER_OVF_EN).
- Reset collision: accept a=1,b=0,cin=0. Next cycle assert rst with in_valid=1 -> first the result (sum=1, out_valid=1) appears, then all outputs are 0 the following cycle.
- Random WIDTH=16: 10k back-to-back valid vectors, compared against fa_add every cycle with 1-cycle alignment.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared constants and a reference adder for the registered ripple-carry full adder.
// fa_add is for benches; the RTL does not call it.
package full_adder_pkg;

   localparam int FA_DEFAULT_WIDTH = 1;
   localparam int FA_MAX_WIDTH     = 64;

   // Returns the (width+1)-bit result {cout,sum} of a+b+cin, zero-extended to FA_MAX_WIDTH+1.
   function automatic logic [FA_MAX_WIDTH:0] fa_add(
      input logic [FA_MAX_WIDTH-1:0] a,
      input logic [FA_MAX_WIDTH-1:0] b,
      input logic                    cin,
      input int unsigned             width
   );
      logic [FA_MAX_WIDTH:0] op_mask;
      logic [FA_MAX_WIDTH:0] res_mask;
      logic [FA_MAX_WIDTH:0] full;
      op_mask  = ({{FA_MAX_WIDTH{1'b0}}, 1'b1} << width) - 1'b1;
      res_mask = ({{FA_MAX_WIDTH{1'b0}}, 1'b1} << (width + 1)) - 1'b1;
      full     = ({1'b0, a} & op_mask) + ({1'b0, b} & op_mask)
               + {{FA_MAX_WIDTH{1'b0}}, cin};
      return full & res_mask;
   endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder cell; the leaf of the ripple-carry chain. Purely combinational.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with a valid strobe and 1-cycle latency.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef FULL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
);

   if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
      $error("full_adder: WIDTH must be in 1..64");
   end

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_core;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      fa_bit u_bit (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry[i]),
         .s  (sum_core[i]),
         .co (carry[i+1])
      );
   end

   // Data registers hold while idle so downstream sees the last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= sum_core;
            cout <= carry[WIDTH];
         end
      end
   end

`ifdef FULL_ADDER_OVF_EN
   // Carry into and out of the sign bit disagree exactly on signed overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: three instances (WIDTH 1, 8, 16) checked every cycle against
// an arithmetic model, plus hand-computed literal vectors. Honours FULL_ADDER_OVF_EN.
module tb_full_adder;
   import full_adder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic        v1 = 0, c1 = 0, v8 = 0, c8 = 0, v16 = 0, c16 = 0;
   logic [0:0]  a1 = 0, b1 = 0;
   logic [7:0]  a8 = 0, b8 = 0;
   logic [15:0] a16 = 0, b16 = 0;

   logic [0:0]  s1;
   logic [7:0]  s8;
   logic [15:0] s16;
   logic        co1, co8, co16, ov1, ov8, ov16;
`ifdef FULL_ADDER_OVF_EN
   logic        of1, of8, of16;
`endif

   full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
`ifdef FULL_ADDER_OVF_EN
      .ovf(of1),
`endif
      .sum(s1), .cout(co1), .out_valid(ov1));

   full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
`ifdef FULL_ADDER_OVF_EN
      .ovf(of8),
`endif
      .sum(s8), .cout(co8), .out_valid(ov8));

   full_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
`ifdef FULL_ADDER_OVF_EN
      .ovf(of16),
`endif
      .sum(s16), .cout(co16), .out_valid(ov16));

   task automatic check(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: expected outputs from plain integer arithmetic and the signed-overflow rule.
   bit      model_ok = 0;
   longint  e_s[3], e_c[3], e_o[3], e_v[3];

   function automatic void model_step(input int k, input int w, input bit v,
                                      input longint ua, input longint ub, input bit ci);
      longint t;
      longint msk;
      msk = (longint'(1) << w) - 1;
      e_v[k] = v;
      if (v) begin
         t      = ua + ub + longint'(ci);
         e_s[k] = t & msk;
         e_c[k] = (t >> w) & 1;
         e_o[k] = (((ua >> (w-1)) & 1) == ((ub >> (w-1)) & 1) &&
                   ((e_s[k] >> (w-1)) & 1) != ((ua >> (w-1)) & 1)) ? 1 : 0;
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         model_ok = 1;
         for (int k = 0; k < 3; k++) begin
            e_s[k] = 0; e_c[k] = 0; e_o[k] = 0; e_v[k] = 0;
         end
      end else begin
         model_step(0, 1,  v1,  longint'(a1),  longint'(b1),  c1);
         model_step(1, 8,  v8,  longint'(a8),  longint'(b8),  c8);
         model_step(2, 16, v16, longint'(a16), longint'(b16), c16);
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("w1_sum",   longint'(s1),   e_s[0]);
         check("w1_cout",  longint'(co1),  e_c[0]);
         check("w1_vld",   longint'(ov1),  e_v[0]);
         check("w8_sum",   longint'(s8),   e_s[1]);
         check("w8_cout",  longint'(co8),  e_c[1]);
         check("w8_vld",   longint'(ov8),  e_v[1]);
         check("w16_sum",  longint'(s16),  e_s[2]);
         check("w16_cout", longint'(co16), e_c[2]);
         check("w16_vld",  longint'(ov16), e_v[2]);
`ifdef FULL_ADDER_OVF_EN
         check("w1_ovf",   longint'(of1),  e_o[0]);
         check("w8_ovf",   longint'(of8),  e_o[1]);
         check("w16_ovf",  longint'(of16), e_o[2]);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] tt [8];
   logic [FA_MAX_WIDTH:0] ref_res;

   initial begin
      tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      ref_res = fa_add(64'hFF, 64'h00, 1'b1, 8);
      check("pkg_ff_00_1", longint'(ref_res[8:0]), 64'h100);
      ref_res = fa_add(64'h7F, 64'h01, 1'b0, 8);
      check("pkg_7f_01_0", longint'(ref_res[8:0]), 64'h080);

      // Reset held with a valid input present: outputs stay cleared.
      rst = 1; v1 = 1; a1 = 1; b1 = 1; c1 = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_sum",  longint'(s1),  0);
         check("rst_cout", longint'(co1), 0);
         check("rst_vld",  longint'(ov1), 0);
      end
      rst = 0;

      for (int i = 0; i < 8; i++) begin
         v1 = 1; {a1, b1, c1} = 3'(i);
         step();
         check("tt_result", longint'({co1, s1}), longint'(tt[i]));
         check("tt_vld",    longint'(ov1), 1);
`ifdef FULL_ADDER_OVF_EN
         check("tt_ovf",    longint'(of1), longint'(tt[i][1] ^ c1));
`endif
      end

      v1 = 1; a1 = 1; b1 = 1; c1 = 0;
      step();
      check("hold_load", longint'({co1, s1}), 2);
      v1 = 0; a1 = 0; b1 = 0; c1 = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_result", longint'({co1, s1}), 2);
         check("hold_vld",    longint'(ov1), 0);
      end

      v8 = 1; a8 = 8'hFF; b8 = 8'h00; c8 = 1;
      step();
      check("w8_wrap_sum",  longint'(s8),  8'h00);
      check("w8_wrap_cout", longint'(co8), 1);
      a8 = 8'h7F; b8 = 8'h01; c8 = 0;
      step();
      check("w8_ovf_sum",  longint'(s8),  8'h80);
      check("w8_ovf_cout", longint'(co8), 0);
`ifdef FULL_ADDER_OVF_EN
      check("w8_ovf_flag", longint'(of8), 1);
`endif
      v8 = 0;

      // Reset collision: the accepted op still shows once, then reset clears it.
      v1 = 1; a1 = 1; b1 = 0; c1 = 0;
      step();
      rst = 1; a1 = 1; b1 = 1; c1 = 1;
      check("coll_sum", longint'(s1),  1);
      check("coll_vld", longint'(ov1), 1);
      step();
      check("coll_clr_sum",  longint'(s1),  0);
      check("coll_clr_cout", longint'(co1), 0);
      check("coll_clr_vld",  longint'(ov1), 0);
      rst = 0; v1 = 0;

      // Back-to-back random vectors on WIDTH=16; WIDTH=8 gets gapped traffic.
      for (int i = 0; i < 10000; i++) begin
         v16 = 1;
         a16 = 16'($urandom());
         b16 = 16'($urandom());
         c16 = 1'($urandom_range(0, 1));
         v8  = 1'($urandom_range(0, 1));
         if (v8) begin
            a8 = 8'($urandom());
            b8 = 8'($urandom());
            c8 = 1'($urandom_range(0, 1));
         end else begin
            a8 = 'x; b8 = 'x; c8 = 'x;
         end
         step();
      end
      v16 = 0; v8 = 0; a8 = 0; b8 = 0; c8 = 0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
